// File: rtl/com_mod_pkg.sv
// Shared types and constants for the com_mod serial transceiver.
package com_mod_pkg;

   localparam int   FRAME_BITS = 10;
   localparam int   DATA_BITS  = 8;
   localparam logic LINE_IDLE  = 1'b1;

   typedef enum logic [1:0] {
      TX_IDLE   = 2'd0,
      TX_LOADED = 2'd1,
      TX_SEND   = 2'd2
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

endpackage

// File: rtl/com_bit_timer.sv
// Bit-period counter with an enable, a synchronous clear and a bit index.
// half_i shortens the current period to BIT_PERIOD/2 so a receiver can land mid-bit.
module com_bit_timer #(
   parameter int BIT_PERIOD = 16,
   parameter int IDX_W      = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             en_i,
   input  logic             half_i,
   output logic             tick_o,
   output logic [IDX_W-1:0] idx_o
);

   localparam int               CNT_W     = $clog2(BIT_PERIOD);
   localparam logic [CNT_W-1:0] FULL_TERM = CNT_W'(BIT_PERIOD - 1);
   localparam logic [CNT_W-1:0] HALF_TERM = CNT_W'(BIT_PERIOD / 2 - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [IDX_W-1:0] idx_q;
   logic [CNT_W-1:0] term;

   assign term   = half_i ? HALF_TERM : FULL_TERM;
   assign tick_o = en_i && (cnt_q == term);
   assign idx_o  = idx_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         cnt_q <= '0;
         idx_q <= '0;
      end else if (en_i) begin
         if (cnt_q == term) begin
            cnt_q <= '0;
            idx_q <= idx_q + 1'b1;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/com_mod.sv
// UART-style transceiver: independent 8N1 transmitter and receiver on CLOCK_50.
// Define COM_MOD_RX_SYNC_EN to pass S_data_in through a 2-flop synchronizer.
module com_mod #(
   parameter int BIT_PERIOD = 16,
   parameter int DATA_BITS  = 8
) (
   input  logic                 CLOCK_50,
   input  logic                 reset,
   input  logic                 transmit_enable,
   input  logic                 load,
   input  logic [DATA_BITS-1:0] P_data_in,
   input  logic                 S_data_in,
   output logic                 S_data_out,
   output logic [DATA_BITS-1:0] P_data_out,
   output logic                 char_sent,
   output logic                 char_received,
   output logic [1:0]           tx_state_o,
   output logic [1:0]           rx_state_o
);

   import com_mod_pkg::*;

   localparam int         IDX_W       = 4;
   localparam logic [3:0] TX_LAST_IDX = 4'(FRAME_BITS - 1);
   localparam logic [3:0] RX_LAST_IDX = 4'(DATA_BITS - 1);

   // ---------------- transmitter ----------------
   tx_state_t              tx_state_q, tx_state_d;
   logic [DATA_BITS+1:0]   frame_q, frame_d;
   logic                   char_sent_q, char_sent_d;
   logic                   tx_tick;
   logic [IDX_W-1:0]       tx_idx;

   com_bit_timer #(.BIT_PERIOD(BIT_PERIOD), .IDX_W(IDX_W)) u_tx_timer (
      .clk_i   (CLOCK_50),
      .rst_i   (reset),
      .clear_i (tx_state_q != TX_SEND),
      .en_i    ((tx_state_q == TX_SEND) && transmit_enable),
      .half_i  (1'b0),
      .tick_o  (tx_tick),
      .idx_o   (tx_idx)
   );

   always_comb begin
      tx_state_d  = tx_state_q;
      frame_d     = frame_q;
      char_sent_d = 1'b0;
      case (tx_state_q)
         TX_IDLE: begin
            if (load) begin
               frame_d    = {1'b1, P_data_in, 1'b0};
               tx_state_d = TX_LOADED;
            end
         end
         TX_LOADED: begin
            if (load) frame_d = {1'b1, P_data_in, 1'b0};
            if (transmit_enable) tx_state_d = TX_SEND;
         end
         TX_SEND: begin
            if (tx_tick) begin
               frame_d = {1'b1, frame_q[DATA_BITS+1:1]};
               if (tx_idx == TX_LAST_IDX) begin
                  tx_state_d  = TX_IDLE;
                  char_sent_d = 1'b1;
               end
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         tx_state_q  <= TX_IDLE;
         frame_q     <= '1;
         char_sent_q <= 1'b0;
      end else begin
         tx_state_q  <= tx_state_d;
         frame_q     <= frame_d;
         char_sent_q <= char_sent_d;
      end
   end

   assign S_data_out = (tx_state_q == TX_SEND) ? frame_q[0] : LINE_IDLE;
   assign char_sent  = char_sent_q;
   assign tx_state_o = tx_state_q;

   // ---------------- receiver ----------------
   logic rx_line;

`ifdef COM_MOD_RX_SYNC_EN
   logic [1:0] sync_q;
   always_ff @(posedge CLOCK_50) begin
      if (reset) sync_q <= {2{LINE_IDLE}};
      else       sync_q <= {sync_q[0], S_data_in};
   end
   assign rx_line = sync_q[1];
`else
   assign rx_line = S_data_in;
`endif

   rx_state_t              rx_state_q, rx_state_d;
   logic                   prev_q;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic [DATA_BITS-1:0]   data_q, data_d;
   logic                   rcv_q, rcv_d;
   logic                   rx_tick;
   logic [IDX_W-1:0]       rx_idx;
   logic                   fall;

   assign fall = prev_q && !rx_line;

   // Timer restarts on the mid-start sample so DATA ticks land mid-bit.
   com_bit_timer #(.BIT_PERIOD(BIT_PERIOD), .IDX_W(IDX_W)) u_rx_timer (
      .clk_i   (CLOCK_50),
      .rst_i   (reset),
      .clear_i ((rx_state_q == RX_IDLE) || ((rx_state_q == RX_START) && rx_tick)),
      .en_i    (1'b1),
      .half_i  (rx_state_q == RX_START),
      .tick_o  (rx_tick),
      .idx_o   (rx_idx)
   );

   always_comb begin
      rx_state_d = rx_state_q;
      shift_d    = shift_q;
      data_d     = data_q;
      rcv_d      = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (fall) rx_state_d = RX_START;
         end
         RX_START: begin
            if (rx_tick) rx_state_d = rx_line ? RX_IDLE : RX_DATA;
         end
         RX_DATA: begin
            if (rx_tick) begin
               shift_d = {rx_line, shift_q[DATA_BITS-1:1]};
               if (rx_idx == RX_LAST_IDX) rx_state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (rx_tick) begin
               if (rx_line) begin
                  data_d = shift_q;
                  rcv_d  = 1'b1;
               end
               rx_state_d = RX_IDLE;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         rx_state_q <= RX_IDLE;
         prev_q     <= LINE_IDLE;
         shift_q    <= '0;
         data_q     <= '0;
         rcv_q      <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         prev_q     <= rx_line;
         shift_q    <= shift_d;
         data_q     <= data_d;
         rcv_q      <= rcv_d;
      end
   end

   assign P_data_out    = data_q;
   assign char_received = rcv_q;
   assign rx_state_o    = rx_state_q;

endmodule

// File: tb/tb_com_mod.sv
// Self-checking bench for com_mod: TX line/pulse model, RX byte scoreboard, loopback.
module tb_com_mod;

`ifdef COM_MOD_RX_SYNC_EN
   localparam int RX_LAT = 155;
`else
   localparam int RX_LAT = 153;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       transmit_enable = 1'b0;
   logic       load = 1'b0;
   logic [7:0] P_data_in = 8'h00;
   logic       rx_drv = 1'b1;
   logic       loop_en = 1'b0;
   logic       rx_in;
   logic       S_data_out;
   logic [7:0] P_data_out;
   logic       char_sent;
   logic       char_received;
   logic [1:0] tx_state_o;
   logic [1:0] rx_state_o;

   int         n_checks = 0;
   int         n_errors = 0;
   int         cyc = 0;
   int         rx_seen = 0;
   logic [7:0] exp_q[$];
   int         start_q[$];

   assign rx_in = loop_en ? S_data_out : rx_drv;

   com_mod dut (
      .CLOCK_50        (clk),
      .reset           (reset),
      .transmit_enable (transmit_enable),
      .load            (load),
      .P_data_in       (P_data_in),
      .S_data_in       (rx_in),
      .S_data_out      (S_data_out),
      .P_data_out      (P_data_out),
      .char_sent       (char_sent),
      .char_received   (char_received),
      .tx_state_o      (tx_state_o),
      .rx_state_o      (rx_state_o)
   );

   // ---------------- clock ----------------
   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // RX scoreboard: every char_received pops one expected byte and start cycle.
   always @(negedge clk) begin
      if (char_received) begin
         rx_seen++;
         if (exp_q.size() == 0) begin
            check("rx_unexpected", 32'd1, 32'd0);
         end else begin
            check("rx_data", {24'd0, P_data_out}, {24'd0, exp_q.pop_front()});
            check("rx_latency", cyc - start_q.pop_front(), RX_LAT);
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic tx_send(input logic [7:0] d, input int pause_len);
      logic [9:0] fr;
      logic       exp_line;
      int         a;
      int         pl;
      int         done_c;
      fr = {1'b1, d, 1'b0};
      @(negedge clk);
      load = 1'b1; P_data_in = d;
      @(negedge clk);
      load = 1'b0; transmit_enable = 1'b1;
      a = 0; pl = pause_len; done_c = -1;
      for (int c = 0; c < 400 && a < 170; c++) begin
         @(negedge clk);
         if (c == 0 && loop_en) begin
            exp_q.push_back(d);
            start_q.push_back(cyc);
         end
         exp_line = (a < 160) ? fr[a / 16] : 1'b1;
         check("tx_line", {31'd0, S_data_out}, {31'd0, exp_line});
         check("tx_sent", {31'd0, char_sent}, {31'd0, (a == 160)});
         if (char_sent) done_c = c;
         // a load while sending must be ignored
         load = (c == 20);
         P_data_in = ~d;
         if (a == 52 && pl > 0) begin
            transmit_enable = 1'b0;
            pl--;
         end else begin
            transmit_enable = 1'b1;
            a++;
         end
      end
      check("tx_done_cycle", done_c, 160 + pause_len);
      check("tx_state_end", {30'd0, tx_state_o}, 32'd0);
      transmit_enable = 1'b0;
   endtask

   task automatic rx_frame(input logic [7:0] d, input logic stop, input bit expect_it);
      logic [9:0] fr;
      fr = {stop, d, 1'b0};
      for (int i = 0; i < 10; i++) begin
         for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            rx_drv = fr[i];
            if (i == 0 && j == 0 && expect_it) begin
               exp_q.push_back(d);
               start_q.push_back(cyc);
            end
         end
      end
      @(negedge clk);
      rx_drv = 1'b1;
      repeat (20) @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] rnd;
      repeat (2) @(negedge clk);
      check("rst_line", {31'd0, S_data_out}, 32'd1);
      check("rst_pdata", {24'd0, P_data_out}, 32'd0);
      check("rst_sent", {31'd0, char_sent}, 32'd0);
      check("rst_rcv", {31'd0, char_received}, 32'd0);
      check("rst_states", {28'd0, tx_state_o, rx_state_o}, 32'd0);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      tx_send(8'hFF, 0);
      repeat (5) @(negedge clk);
      tx_send(8'hA5, 40);
      repeat (5) @(negedge clk);

      // reset in the middle of a frame returns the line to idle
      @(negedge clk);
      load = 1'b1; P_data_in = 8'h00;
      @(negedge clk);
      load = 1'b0; transmit_enable = 1'b1;
      repeat (30) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_line", {31'd0, S_data_out}, 32'd1);
      check("midrst_state", {30'd0, tx_state_o}, 32'd0);
      reset = 1'b0;
      repeat (20) begin
         @(negedge clk);
         check("midrst_idle", {31'd0, S_data_out}, 32'd1);
      end
      transmit_enable = 1'b0;

      rx_frame(8'h3C, 1'b1, 1'b1);
      check("rx_3c_out", {24'd0, P_data_out}, 32'h3C);

      // short low glitch is rejected as a false start
      @(negedge clk);
      rx_drv = 1'b0;
      repeat (4) @(negedge clk);
      rx_drv = 1'b1;
      repeat (200) @(negedge clk);
      check("glitch_hold", {24'd0, P_data_out}, 32'h3C);
      check("glitch_state", {30'd0, rx_state_o}, 32'd0);

      rx_frame(8'h55, 1'b0, 1'b0);
      check("frame_err_hold", {24'd0, P_data_out}, 32'h3C);

      rnd = 8'($urandom_range(0, 255));
      rx_frame(rnd, 1'b1, 1'b1);
      check("rx_rnd_out", {24'd0, P_data_out}, {24'd0, rnd});

      loop_en = 1'b1;
      tx_send(8'h81, 0);
      repeat (40) @(negedge clk);
      loop_en = 1'b0;
      check("loop_out", {24'd0, P_data_out}, 32'h81);

      check("rx_pending", exp_q.size(), 32'd0);
      check("rx_count", rx_seen, 32'd3);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
